// File: rtl/alu_mult_sequencer_pkg.sv
// rtl/alu_mult_sequencer_pkg.sv - shared FSM encoding and ALU operation codes
package alu_mult_sequencer_pkg;

    // Sequencer FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ALU operacion_i codes, shared with the main control unit
    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT = 4'b0111;

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// rtl/alu_mult_sequencer_if.sv - control-unit handshake and shared-ALU bus of the multiply sequencer
interface alu_mult_sequencer_if #(
    parameter int N = 32
);
    // Control unit handshake
    logic             start_i;
    logic [N-1:0]     multiplicando_i;
    logic [N-1:0]     multiplicador_i;
    logic             busy_o;
    logic             done_o;
    logic [2*N-1:0]   producto_o;

    // Shared ALU operand/result bus
    logic             alu_sel_o;
    logic [N-1:0]     alu_a_o;
    logic [N-1:0]     alu_b_o;
    logic             alu_c_o;
    logic             alu_invert_o;
    logic [3:0]       alu_operacion_o;
    logic [N-1:0]     alu_resultado_i;
    logic             alu_c_i;

    // Control unit + datapath side
    modport master (
        output start_i, multiplicando_i, multiplicador_i,
        output alu_resultado_i, alu_c_i,
        input  busy_o, done_o, producto_o,
        input  alu_sel_o, alu_a_o, alu_b_o, alu_c_o, alu_invert_o, alu_operacion_o
    );

    // Sequencer side
    modport slave (
        input  start_i, multiplicando_i, multiplicador_i,
        input  alu_resultado_i, alu_c_i,
        output busy_o, done_o, producto_o,
        output alu_sel_o, alu_a_o, alu_b_o, alu_c_o, alu_invert_o, alu_operacion_o
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - iterative shift-and-add N x N multiplier time-sharing the datapath ALU
module alu_mult_sequencer
    import alu_mult_sequencer_pkg::*;
#(
    parameter int         N      = 32,
    parameter logic [3:0] OP_ADD = ALU_OP_ADD
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_mult_sequencer_if.slave  bus
);

    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic            done_q, done_d;

    logic            run;

    assign run = (state_q == ST_RUN);

    // Next-state logic: latch operands, one ALU add + right shift per multiplier bit, publish product
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        count_d = count_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    hi_d    = '0;
                    lo_d    = bus.multiplicador_i;
                    mcand_d = bus.multiplicando_i;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The ALU carry becomes the top bit, so the partial product never overflows;
                // the low bit of the sum shifts into lo as the consumed multiplier bit leaves.
                hi_d = {bus.alu_c_i, bus.alu_resultado_i[N-1:1]};
                lo_d = {bus.alu_resultado_i[0], lo_q[N-1:1]};
                if (count_q == LAST) begin
                    // Counter parks at its terminal value; it is re-zeroed by the next start.
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                prod_d  = {hi_q, lo_q};
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            count_q <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    // ALU operand drive, decoded from state; held at a quiet add while the datapath owns the ALU
    always_comb begin
        bus.alu_sel_o       = 1'b0;
        bus.alu_a_o         = '0;
        bus.alu_b_o         = '0;
        bus.alu_c_o         = 1'b0;
        bus.alu_invert_o    = 1'b0;
        bus.alu_operacion_o = OP_ADD;
        if (run) begin
            bus.alu_sel_o = 1'b1;
            bus.alu_a_o   = hi_q;
            bus.alu_b_o   = lo_q[0] ? mcand_q : '0;
        end
    end

    // Handshake outputs toward the control unit
    always_comb begin
        bus.busy_o     = (state_q != ST_IDLE);
        bus.done_o     = done_q;
        bus.producto_o = prod_q;
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - scoreboard bench for alu_mult_sequencer with a behavioural ALU
module tb_alu_mult_sequencer;
    import alu_mult_sequencer_pkg::*;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] prod;
    } op_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_mult_sequencer_if #(.N(N)) ifc ();

    alu_mult_sequencer #(.N(N), .OP_ADD(ALU_OP_ADD)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    // Behavioural stand-in for the shared N-bit ALU
    logic [N-1:0] alu_bop;
    logic [N:0]   alu_sum;
    always_comb begin
        alu_bop = ifc.alu_invert_o ? ~ifc.alu_b_o : ifc.alu_b_o;
        alu_sum = {1'b0, ifc.alu_a_o} + {1'b0, alu_bop} + {{N{1'b0}}, ifc.alu_c_o};
        ifc.alu_resultado_i = alu_sum[N-1:0];
        ifc.alu_c_i         = alu_sum[N];
        case (ifc.alu_operacion_o)
            ALU_OP_AND: begin
                ifc.alu_resultado_i = ifc.alu_a_o & alu_bop;
                ifc.alu_c_i         = 1'b0;
            end
            ALU_OP_OR: begin
                ifc.alu_resultado_i = ifc.alu_a_o | alu_bop;
                ifc.alu_c_i         = 1'b0;
            end
            default: begin
            end
        endcase
    end

    op_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: per-cycle ALU-drive checks and product/timing checks whenever done_o is seen
    int   cyc = 0;
    int   busy_cnt = 0;
    int   rise_cyc = 0;
    int   run_idx = 0;
    logic busy_prev = 1'b0;
    logic tracking = 1'b0;
    op_t  mon_op;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            busy_prev = 1'b0;
            tracking  = 1'b0;
            busy_cnt  = 0;
            run_idx   = 0;
        end else begin
            if (ifc.busy_o && !busy_prev) begin
                rise_cyc = cyc;
                busy_cnt = 0;
                run_idx  = 0;
                tracking = (exp_q.size() != 0);
            end
            if (ifc.busy_o) busy_cnt++;
            if (ifc.alu_sel_o) begin
                check("run_ctrl", {ifc.alu_operacion_o, ifc.alu_invert_o, ifc.alu_c_o},
                      {ALU_OP_ADD, 2'b00});
                if (tracking && run_idx < N)
                    check("run_b", ifc.alu_b_o,
                          exp_q[0].b[run_idx] ? exp_q[0].a : {N{1'b0}});
                run_idx++;
            end else if (ifc.busy_o && tracking) begin
                check("run_len", run_idx, N);
                check("done_state_alu_idle",
                      {ifc.alu_a_o, ifc.alu_b_o, ifc.alu_c_o, ifc.alu_invert_o}, '0);
            end
            if (ifc.done_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_op = exp_q.pop_front();
                    check("product", ifc.producto_o, mon_op.prod);
                    check("done_latency", cyc - rise_cyc, N + 1);
                    check("busy_len", busy_cnt, N + 1);
                    check("busy_in_done", ifc.busy_o, 0);
                end
                tracking = 1'b0;
            end
            busy_prev = ifc.busy_o;
        end
    end

    // Issue a multiply in a cycle where the sequencer is idle (or pulsing done_o)
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        op_t e;
        e.a    = a;
        e.b    = b;
        e.prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        ifc.start_i         = 1'b1;
        ifc.multiplicando_i = a;
        ifc.multiplicador_i = b;
        exp_q.push_back(e);
        @(posedge clk); #1;
        ifc.start_i         = 1'b0;
        ifc.multiplicando_i = $urandom;
        ifc.multiplicador_i = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (ifc.done_o) return;
            @(posedge clk); #1;
        end
        check("done_timeout", 0, 1);
    endtask

    function automatic logic [N-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return N'(1);
            3:       return {1'b1, {(N-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen_done;
        rst                 = 1'b1;
        ifc.start_i         = 1'b0;
        ifc.multiplicando_i = '0;
        ifc.multiplicador_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", ifc.busy_o, 0);
        check("reset_done", ifc.done_o, 0);
        check("reset_alu_sel", ifc.alu_sel_o, 0);
        check("reset_product", ifc.producto_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(32'd3, 32'd5);
        wait_done();
        check("product_3x5", ifc.producto_o, 64'h0F);
        @(posedge clk); #1;

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        check("product_max", ifc.producto_o, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;

        issue(32'd0, 32'h1234_5678);
        wait_done();
        @(posedge clk); #1;
        issue(32'h1234_5678, 32'd0);
        wait_done();
        @(posedge clk); #1;

        // Start re-pulsed mid-run must be ignored
        issue(32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        ifc.start_i         = 1'b1;
        ifc.multiplicando_i = 32'd2;
        ifc.multiplicador_i = 32'd2;
        @(posedge clk); #1;
        ifc.start_i = 1'b0;
        wait_done();
        check("product_7x9", ifc.producto_o, 64'd63);

        // Start in the done_o cycle is accepted
        issue(32'd11, 32'd13);
        wait_done();

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
            issue(pick_operand(), pick_operand());
            wait_done();
        end
        @(posedge clk); #1;

        // Reset during RUN cycle 10 aborts the operation
        issue($urandom, $urandom);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", ifc.busy_o, 0);
        check("abort_alu_sel", ifc.alu_sel_o, 0);
        check("abort_product", ifc.producto_o, 0);
        seen_done = 1'b0;
        repeat (40) begin
            if (ifc.done_o) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        check("no_done_after_abort", seen_done, 0);

        issue(32'hDEAD_BEEF, 32'h0000_1001);
        wait_done();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
